// File: rtl/swt16_pkg.sv
// Shared SWT16 front-end definitions: fetch FSM encodings and default address widths.
// The decoder uses the same widths for its in_pc input.
package swt16_pkg;

  localparam int unsigned PcWidth       = 12;
  localparam int unsigned PmemAddrWidth = 12;

  typedef enum logic [1:0] {
    StBoot  = 2'd0,
    StRun   = 2'd1,
    StFlush = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl.sv
// SWT16 program-counter sequencer: drives the program-memory read address, tracks the PC of
// the word on the instruction bus, and handles jump redirects with a fixed-length decoder flush.
module fetch_ctrl
  import swt16_pkg::*;
#(
  parameter int unsigned PC_WIDTH        = PcWidth,
  parameter int unsigned PMEM_ADDR_WIDTH = PmemAddrWidth,
  parameter int unsigned RESET_PC        = 0,
  parameter int unsigned FLUSH_CYCLES    = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_jump,
  input  logic [PC_WIDTH-1:0]        in_jump_target,
  input  logic                       in_stall,
  output logic [PMEM_ADDR_WIDTH-1:0] out_pmem_addr,
  output logic [PC_WIDTH-1:0]        out_pc,
  output logic                       out_flush,
  output logic [1:0]                 out_state
);

  localparam logic [PC_WIDTH-1:0] ResetPc   = PC_WIDTH'(RESET_PC);
  localparam logic [2:0]          FlushInit = 3'(FLUSH_CYCLES - 1);

  logic [PC_WIDTH-1:0] fetch_pc_q;
  logic [PC_WIDTH-1:0] out_pc_q;
  logic [2:0]          flush_cnt_q;
  logic                out_flush_q;
  fetch_state_e        state_q;

  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] addr_sel;

  assign pc_inc = fetch_pc_q + PC_WIDTH'(1);

  // While stalled in RUN, re-read the word already on the bus so it stays valid.
  always_comb begin
    addr_sel = fetch_pc_q;
    if (state_q == StRun && in_stall && !in_jump) begin
      addr_sel = out_pc_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q  <= ResetPc;
      out_pc_q    <= '0;
      flush_cnt_q <= '0;
      out_flush_q <= 1'b1;
      state_q     <= StBoot;
    end else if (in_jump) begin
      fetch_pc_q  <= in_jump_target;
      flush_cnt_q <= FlushInit;
      out_flush_q <= 1'b1;
      state_q     <= StFlush;
    end else begin
      case (state_q)
        StRun: begin
          if (!in_stall) begin
            out_pc_q   <= fetch_pc_q;
            fetch_pc_q <= pc_inc;
          end
        end
        StFlush: begin
          if (flush_cnt_q != 3'd0) begin
            flush_cnt_q <= flush_cnt_q - 3'd1;
          end else begin
            out_pc_q    <= fetch_pc_q;
            fetch_pc_q  <= pc_inc;
            out_flush_q <= 1'b0;
            state_q     <= StRun;
          end
        end
        // BOOT, and the unused encoding, start the run at the current fetch address.
        default: begin
          out_pc_q    <= fetch_pc_q;
          fetch_pc_q  <= pc_inc;
          out_flush_q <= 1'b0;
          state_q     <= StRun;
        end
      endcase
    end
  end

  assign out_pmem_addr = PMEM_ADDR_WIDTH'(addr_sel);
  assign out_pc        = out_pc_q;
  assign out_flush     = out_flush_q;
  assign out_state     = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, hand-written redirect/wrap/reset sequences,
// and randomized traffic checked against a redirect-timer reference model.
module tb_fetch_ctrl;

  localparam int unsigned PW  = 12;
  localparam int unsigned FC  = 2;
  localparam int unsigned RPC = 0;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_jump = 1'b0;
  logic          in_stall = 1'b0;
  logic [PW-1:0] in_jump_target = '0;
  logic [PW-1:0] out_pmem_addr;
  logic [PW-1:0] out_pc;
  logic          out_flush;
  logic [1:0]    out_state;

  int total = 0;
  int bad   = 0;

  // Reference model: reset behaves like a redirect to RESET_PC with a one-cycle flush.
  int m_next;
  int m_pc;
  int m_pending;
  bit m_boot;

  typedef struct {
    bit rst;
    bit jmp;
    bit stl;
    int tgt;
    int addr;
    int pc;
    int flush;
    int st;
  } vec_t;

  vec_t tbl[$];

  always #5 clock = ~clock;

  fetch_ctrl #(
    .PC_WIDTH       (PW),
    .PMEM_ADDR_WIDTH(PW),
    .RESET_PC       (RPC),
    .FLUSH_CYCLES   (FC)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .in_jump       (in_jump),
    .in_jump_target(in_jump_target),
    .in_stall      (in_stall),
    .out_pmem_addr (out_pmem_addr),
    .out_pc        (out_pc),
    .out_flush     (out_flush),
    .out_state     (out_state)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit r, input bit j, input int t, input bit s);
    @(negedge clock);
    reset          = r;
    in_jump        = j;
    in_jump_target = t[PW-1:0];
    in_stall       = s;
    #1;
  endtask

  task automatic model_edge();
    if (reset) begin
      m_next = RPC; m_pc = 0; m_pending = 1; m_boot = 1'b1;
    end else if (in_jump) begin
      m_next = int'(in_jump_target); m_pending = FC; m_boot = 1'b0;
    end else if (m_pending > 1) begin
      m_pending--;
    end else if (m_pending == 1 || !in_stall) begin
      m_pc = m_next; m_next = (m_next + 1) % (1 << PW); m_pending = 0; m_boot = 1'b0;
    end
  endtask

  task automatic check_model(input string tag);
    int exp_addr;
    int exp_st;
    exp_addr = (m_pending == 0 && in_stall && !in_jump) ? m_pc : m_next;
    exp_st   = (m_pending == 0) ? 1 : (m_boot ? 0 : 2);
    chk({tag, "_addr"}, int'(out_pmem_addr), exp_addr);
    chk({tag, "_pc"}, int'(out_pc), m_pc);
    chk({tag, "_flush"}, int'(out_flush), int'(m_pending > 0));
    chk({tag, "_state"}, int'(out_state), exp_st);
  endtask

  task automatic finish_cycle();
    @(posedge clock);
    model_edge();
  endtask

  task automatic step(input bit r, input bit j, input int t, input bit s, input string tag);
    drive(r, j, t, s);
    check_model(tag);
    finish_cycle();
  endtask

  task automatic add(input bit r, input bit j, input bit s, input int t,
                     input int a, input int p, input int f, input int st);
    vec_t v;
    v.rst = r; v.jmp = j; v.stl = s; v.tgt = t;
    v.addr = a; v.pc = p; v.flush = f; v.st = st;
    tbl.push_back(v);
  endtask

  initial begin
    int nflush;
    bit seen_first;
    bit seen_040;

    // Reset, release, sequential fetch, stall, jump, jump-with-stall.
    add(1, 0, 0, 0,     'h000, 'h000, 1, 0);
    add(0, 0, 0, 0,     'h000, 'h000, 1, 0);
    add(0, 0, 0, 0,     'h001, 'h000, 0, 1);
    add(0, 0, 0, 0,     'h002, 'h001, 0, 1);
    add(0, 0, 0, 0,     'h003, 'h002, 0, 1);
    add(0, 0, 0, 0,     'h004, 'h003, 0, 1);
    add(0, 0, 0, 0,     'h005, 'h004, 0, 1);
    add(0, 0, 1, 0,     'h005, 'h005, 0, 1);
    add(0, 0, 1, 0,     'h005, 'h005, 0, 1);
    add(0, 0, 1, 0,     'h005, 'h005, 0, 1);
    add(0, 0, 0, 0,     'h006, 'h005, 0, 1);
    add(0, 0, 0, 0,     'h007, 'h006, 0, 1);
    add(0, 0, 0, 0,     'h008, 'h007, 0, 1);
    add(0, 1, 0, 'h100, 'h009, 'h008, 0, 1);
    add(0, 0, 0, 0,     'h100, 'h008, 1, 2);
    add(0, 0, 0, 0,     'h100, 'h008, 1, 2);
    add(0, 0, 0, 0,     'h101, 'h100, 0, 1);
    add(0, 1, 1, 'h200, 'h102, 'h101, 0, 1);
    add(0, 0, 0, 0,     'h200, 'h101, 1, 2);
    add(0, 0, 1, 0,     'h200, 'h101, 1, 2);
    add(0, 0, 0, 0,     'h201, 'h200, 0, 1);
    add(0, 0, 0, 0,     'h202, 'h201, 0, 1);

    reset = 1'b1;
    @(posedge clock);
    model_edge();

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].jmp, tbl[i].tgt, tbl[i].stl);
      chk($sformatf("vec%0d_addr", i), int'(out_pmem_addr), tbl[i].addr);
      chk($sformatf("vec%0d_pc", i), int'(out_pc), tbl[i].pc);
      chk($sformatf("vec%0d_flush", i), int'(out_flush), tbl[i].flush);
      chk($sformatf("vec%0d_state", i), int'(out_state), tbl[i].st);
      finish_cycle();
    end

    // Back-to-back jumps: the second target wins and the flush restarts.
    step(0, 1, 'h040, 0, "s4_j1");
    step(0, 1, 'h080, 0, "s4_j2");
    nflush = 0; seen_first = 1'b0; seen_040 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      drive(0, 0, 0, 0);
      check_model($sformatf("s4_c%0d", k));
      if (out_flush) begin
        nflush++;
      end else begin
        if (out_pc == PW'('h040)) seen_040 = 1'b1;
        if (!seen_first) begin
          seen_first = 1'b1;
          chk("s4_first_pc", int'(out_pc), 'h080);
          chk("s4_flush_len", nflush, FC);
        end
      end
      finish_cycle();
    end
    chk("s4_saw_unflushed", int'(seen_first), 1);
    chk("s4_no_040", int'(seen_040), 0);

    // Wrap from 0xFFF to 0x000 without flushing.
    step(0, 1, 'hFFE, 0, "s6_j");
    step(0, 0, 0, 0, "s6_f0");
    step(0, 0, 0, 0, "s6_f1");
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0);
      check_model($sformatf("s6_c%0d", k));
      chk($sformatf("s6_pc%0d", k), int'(out_pc), ('hFFE + k) % 'h1000);
      chk($sformatf("s6_flush%0d", k), int'(out_flush), 0);
      finish_cycle();
    end

    // Reset in the middle of a flush.
    step(0, 1, 'h123, 0, "s7_j");
    step(0, 0, 0, 0, "s7_f");
    step(1, 0, 0, 0, "s7_rst");
    drive(0, 0, 0, 0);
    chk("s7_state", int'(out_state), 0);
    chk("s7_pc", int'(out_pc), 0);
    chk("s7_flush", int'(out_flush), 1);
    chk("s7_addr", int'(out_pmem_addr), RPC);
    finish_cycle();

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      step(($urandom % 100) == 0, ($urandom % 10) == 0, int'($urandom % 4096),
           ($urandom % 4) == 0, $sformatf("rnd%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
